alu_rr_arbiter: RTL and testbench

//  Shares one registered ALU32 (one-cycle result latency, combinational Zero) among NUM_REQ requesters.
//  - Requesters hand over operations with a valid/ready handshake.
//  - Operations are granted round-robin and driven onto the ALU inputs.
//  - The ALU's registered Result and the issue-cycle Zero are returned through a single response channel with a requester id.

---
 rtl/alu_rr_arbiter.sv | 152 +++++++++++++++
 tb/tb_alu_rr_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: round-robin front end that shares one registered ALU32
// among NUM_REQ requesters and returns each result with its owner's id.
//
// Handshakes: on every channel a word moves on a rising edge where valid and
// ready are both high. A requester holds its valid and operands until it sees
// ready. The response holds resp_* stable until resp_ready is seen in RESP.
//
// The FSM state is kept in the named register `state` so that checkers can
// reach it hierarchically. A legal op steps IDLE -> ISSUE -> CAPT -> RESP.
// An illegal op goes IDLE -> RESP and never touches the ALU.
module alu_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [4*NUM_REQ-1:0]    req_op,
  input  logic [32*NUM_REQ-1:0]   req_a,
  input  logic [32*NUM_REQ-1:0]   req_b,
  output logic [31:0]             alu_in1,
  output logic [31:0]             alu_in2,
  output logic [3:0]              alu_op,
  input  logic [31:0]             alu_result,
  input  logic                    alu_zero,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [ID_W-1:0]         resp_id,
  output logic [31:0]             resp_result,
  output logic                    resp_zero,
  output logic                    resp_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;

  // One extra bit so that pointer + offset cannot overflow before wrapping.
  localparam int SW = ID_W + 1;

  state_t          state;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] owner;
  logic [ID_W-1:0] winner;
  logic            found;
  logic [3:0]      win_op;
  logic [31:0]     win_a;
  logic [31:0]     win_b;

  // Opcodes the ALU implements: AND, OR, ADD, SUB, SLT, NOR.
  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: op_legal = 1'b1;
      default:                                              op_legal = 1'b0;
    endcase
  endfunction

  // Round-robin search: first valid requester after the last winner, wrapping.
  always_comb begin
    logic [SW-1:0] sum;
    winner = '0;
    found  = 1'b0;
    sum    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum = SW'(ptr) + SW'(k);
      if (sum >= SW'(NUM_REQ)) sum = sum - SW'(NUM_REQ);
      if (!found && req_valid[sum[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = sum[ID_W-1:0];
      end
    end
  end

  // Select the winning requester's operation fields.
  always_comb begin
    win_op = '0;
    win_a  = '0;
    win_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        win_op = req_op[4*i +: 4];
        win_a  = req_a[32*i +: 32];
        win_b  = req_b[32*i +: 32];
      end
    end
  end

  // Grant only in IDLE, and only to the winner, so req_ready is one-hot or zero.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && found) req_ready[winner] = 1'b1;
  end

  // Control FSM with registered ALU drive and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= ID_W'(NUM_REQ - 1);
      owner       <= '0;
      alu_in1     <= '0;
      alu_in2     <= '0;
      alu_op      <= 4'b0000;
      resp_valid  <= 1'b0;
      resp_id     <= '0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
      resp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            owner <= winner;
            ptr   <= winner;
            if (op_legal(win_op)) begin
              alu_op  <= win_op;
              alu_in1 <= win_a;
              alu_in2 <= win_b;
              state   <= ISSUE;
            end else begin
              // Reject without using the ALU; the drive registers keep their value.
              resp_id     <= winner;
              resp_result <= '0;
              resp_zero   <= 1'b0;
              resp_err    <= 1'b1;
              resp_valid  <= 1'b1;
              state       <= RESP;
            end
          end
        end
        ISSUE: begin
          // Zero is combinational on the stable inputs; the ALU registers its result on this edge.
          resp_zero <= alu_zero;
          state     <= CAPT;
        end
        CAPT: begin
          resp_result <= alu_result;
          resp_id     <= owner;
          resp_err    <= 1'b0;
          resp_valid  <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb_alu_rr_arbiter: directed bench for alu_rr_arbiter with a behavioural
// ALU32 (registered Result, combinational Zero) attached to the ALU ports.
module tb_alu_rr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                  clk;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [4*NUM_REQ-1:0]  req_op;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic [31:0]           alu_in1;
  logic [31:0]           alu_in2;
  logic [3:0]            alu_op;
  logic [31:0]           alu_result;
  logic                  alu_zero;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [ID_W-1:0]       resp_id;
  logic [31:0]           resp_result;
  logic                  resp_zero;
  logic                  resp_err;

  int total;
  int bad;
  logic [31:0] exp_q[$];

  alu_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_result(resp_result),
    .resp_zero(resp_zero), .resp_err(resp_err)
  );

  // clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural ALU32
  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0000: alu_f = a & b;
      4'b0001: alu_f = a | b;
      4'b0010: alu_f = a + b;
      4'b0110: alu_f = a - b;
      4'b0111: alu_f = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: alu_f = ~(a | b);
      default: alu_f = 32'd0;
    endcase
  endfunction

  always @(posedge clk) alu_result <= alu_f(alu_op, alu_in1, alu_in2);
  assign alu_zero = (alu_in1 == alu_in2);

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic set_req(input int idx, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[4*idx +: 4]  = op;
    req_a[32*idx +: 32] = a;
    req_b[32*idx +: 32] = b;
  endtask

  // One operation from a lone requester with resp_ready high. exp_lat counts
  // edges from the transfer edge (inclusive) to the first resp_valid sample.
  task automatic do_op(input string tag, input int idx, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e_res, input logic e_zero, input logic e_err,
                       input int exp_lat);
    int lat;
    set_req(idx, op, a, b);
    req_valid      = '0;
    req_valid[idx] = 1'b1;
    #1;
    check({tag, "_ready"}, 32'(req_ready), 32'(1) << idx);
    step();
    req_valid = '0;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      step();
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_id"}, 32'(resp_id), idx);
    check({tag, "_res"}, resp_result, e_res);
    check({tag, "_zero"}, 32'(resp_zero), 32'(e_zero));
    check({tag, "_err"}, 32'(resp_err), 32'(e_err));
    step();
    check({tag, "_done"}, 32'(resp_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b0;
    req_valid = '0;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    resp_ready = 1'b1;
    do_reset();

    // reset values
    check("rst_valid", 32'(resp_valid), 0);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_id", 32'(resp_id), 0);
    check("rst_res", resp_result, 0);
    check("rst_zero", 32'(resp_zero), 0);
    check("rst_err", 32'(resp_err), 0);
    check("rst_in1", alu_in1, 0);
    check("rst_in2", alu_in2, 0);
    check("rst_op", 32'(alu_op), 0);

    // requester 0 alone: 5 + 7
    do_op("t1_add", 0, 4'b0010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 3);
    check("t1_alu_op", 32'(alu_op), 32'h2);
    check("t1_alu_in1", alu_in1, 32'd5);

    // zero alignment
    do_op("t2_eq", 0, 4'b0110, 32'h1234, 32'h1234, 32'd0, 1'b1, 1'b0, 3);
    do_op("t2_ne", 0, 4'b0110, 32'd1, 32'd2, 32'hffff_ffff, 1'b0, 1'b0, 3);
    do_op("t2_slt", 1, 4'b0111, 32'hffff_fffe, 32'd3, 32'd1, 1'b0, 1'b0, 3);
    do_op("t2_nor", 3, 4'b1100, 32'h0f0f_0000, 32'h0000_00ff, 32'hf0f0_ff00, 1'b0, 1'b0, 3);

    // four requesters continuously valid from reset: 0,1,2,3,0,... in 4 cycles each
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 4'b0010, 32'(i * 10), 32'd1);
    for (int n = 0; n < 8; n++) exp_q.push_back(32'((n % 4) * 10 + 1));
    req_valid = 4'b1111;
    #1;
    for (int n = 0; n < 8; n++) begin
      check("t3_grant", 32'(req_ready), 32'(1) << (n % 4));
      step();
      check("t3_issue_nv", 32'(resp_valid), 0);
      step();
      step();
      check("t3_valid", 32'(resp_valid), 1);
      check("t3_id", 32'(resp_id), n % 4);
      check("t3_res", resp_result, exp_q.pop_front());
      step();
    end
    req_valid = '0;

    // backpressure in RESP
    resp_ready = 1'b0;
    set_req(1, 4'b0001, 32'hf0, 32'h0f);
    req_valid = 4'b0010;
    #1;
    check("t4_grant", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    step();
    step();
    check("t4_valid0", 32'(resp_valid), 1);
    check("t4_res0", resp_result, 32'hff);
    req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      step();
      check("t4_hold_valid", 32'(resp_valid), 1);
      check("t4_hold_res", resp_result, 32'hff);
      check("t4_hold_id", 32'(resp_id), 1);
      check("t4_hold_ready", 32'(req_ready), 0);
    end
    resp_ready = 1'b1;
    step();
    check("t4_release", 32'(resp_valid), 0);
    check("t4_idle_grant", 32'(req_ready != 0), 1);
    req_valid = '0;

    // illegal opcode from requester 2: response one edge after transfer
    do_op("t5_ill", 2, 4'b1111, 32'd9, 32'd9, 32'd0, 1'b0, 1'b1, 1);
    check("t5_alu_op_kept", 32'(alu_op), 32'h1);

    // reset in CAPT discards the operation
    set_req(3, 4'b0010, 32'd3, 32'd4);
    req_valid = 4'b1000;
    #1;
    check("t6_grant", 32'(req_ready), 32'h8);
    step();
    req_valid = '0;
    step();
    check("t6_capt_nv", 32'(resp_valid), 0);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(resp_valid), 0);
    check("t6_rst_res", resp_result, 0);
    check("t6_rst_op", 32'(alu_op), 0);
    check("t6_rst_in1", alu_in1, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      check("t6_no_resp", 32'(resp_valid), 0);
    end
    req_valid = 4'b1111;
    #1;
    check("t6_first_grant", 32'(req_ready), 32'h1);
    req_valid = '0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
